// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised counter family.
package counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;
    localparam bit DIR_DOWN  = 1'b0;
    localparam bit DIR_UP    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A DIV of 1 still needs a one-bit register so the prescaler keeps a uniform shape.
    function automatic int pre_width(input int div);
        return (clog2(div) < 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable generator: tick is high for one enabled cycle out of every DIV.
module clk_en_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PW   = pre_width(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == LAST) ? '0 : pre + 1'b1;
        end
    end

    assign tick = (pre == LAST);

endmodule

// File: rtl/param_updown_counter.sv
// Up/down modulo counter with parallel load, wrap/saturate boundary, prescaled
// stepping, cascadable terminal count and a sticky overflow flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH,
    parameter int DIV     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MAX   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   din_ext;
    logic             at_max;
    logic             at_zero;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] next_q;

    clk_en_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // Compare one bit wider than the count so din values above MAX clamp correctly.
    assign q_ext    = {1'b0, Q};
    assign din_ext  = {1'b0, din};
    assign at_max   = (q_ext == MAX);
    assign at_zero  = (Q == '0);
    assign step     = en & tick & ~load;
    assign boundary = step & ((up == DIR_UP) ? at_max : at_zero);
    assign tc       = en & tick & ((up & at_max) | (~up & at_zero));

    always_comb begin
        next_q = Q;
        if (load) begin
            next_q = (din_ext > MAX) ? MAX_Q : din;
        end else if (step) begin
            if (up == DIR_UP) begin
                next_q = at_max ? ((sat == MODE_SAT) ? MAX_Q : '0)
                                : WIDTH'(q_ext + 1'b1);
            end else begin
                next_q = at_zero ? ((sat == MODE_WRAP) ? MAX_Q : '0)
                                 : WIDTH'(q_ext - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Q <= '0;
        end else begin
            Q <= next_q;
        end
    end

    // A boundary step on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three shared-stimulus configurations plus a decade cascade.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, sat, ovf_clr;
    logic [3:0] din;
    logic       rst_k;

    logic [3:0] q_a, q_b, q_c, q_k0, q_k1;
    logic       tc_a, tc_b, tc_c, tc_k0, tc_k1;
    logic       ovf_a, ovf_b, ovf_c, ovf_k0, ovf_k1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .sat(sat),
        .ovf_clr(ovf_clr), .Q(q_a), .tc(tc_a), .ovf(ovf_a));

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .sat(sat),
        .ovf_clr(ovf_clr), .Q(q_b), .tc(tc_b), .ovf(ovf_b));

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .sat(sat),
        .ovf_clr(ovf_clr), .Q(q_c), .tc(tc_c), .ovf(ovf_c));

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) dut_k0 (
        .clk(clk), .rst(rst_k), .en(1'b1), .up(1'b1), .load(1'b0), .din(4'd0), .sat(1'b0),
        .ovf_clr(1'b0), .Q(q_k0), .tc(tc_k0), .ovf(ovf_k0));

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) dut_k1 (
        .clk(clk), .rst(rst_k), .en(tc_k0), .up(1'b1), .load(1'b0), .din(4'd0), .sat(1'b0),
        .ovf_clr(1'b0), .Q(q_k1), .tc(tc_k1), .ovf(ovf_k1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: counter value as an integer in 0..MOD-1, prescaler as a phase count.
    int modv[3] = '{16, 10, 16};
    int divv[3] = '{1, 1, 3};
    int mq[3], movf[3], mpre[3];
    int kn;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int mx;
            bit stp, bnd;
            mx = modv[i] - 1;
            if (!rst) begin
                mq[i] = 0; movf[i] = 0; mpre[i] = 0;
            end else if (load) begin
                mq[i]   = (int'(din) > mx) ? mx : int'(din);
                mpre[i] = 0;
                if (ovf_clr) movf[i] = 0;
            end else begin
                stp = en && (mpre[i] == divv[i] - 1);
                bnd = stp && (up ? (mq[i] == mx) : (mq[i] == 0));
                if (en) mpre[i] = (mpre[i] + 1) % divv[i];
                if (stp) begin
                    if (up) mq[i] = sat ? ((mq[i] + 1 > mx) ? mx : mq[i] + 1) : (mq[i] + 1) % modv[i];
                    else    mq[i] = sat ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1) : (mq[i] + modv[i] - 1) % modv[i];
                end
                if (bnd) movf[i] = 1;
                else if (ovf_clr) movf[i] = 0;
            end
        end
        if (!rst_k) kn = 0;
        else        kn = kn + 1;
        if (!rst && !rst_k) mvalid = 1'b1;
    end

    logic [3:0] qv[3];
    logic       tv[3], ov[3];
    assign qv[0] = q_a;   assign qv[1] = q_b;   assign qv[2] = q_c;
    assign tv[0] = tc_a;  assign tv[1] = tc_b;  assign tv[2] = tc_c;
    assign ov[0] = ovf_a; assign ov[1] = ovf_b; assign ov[2] = ovf_c;

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                bit etc;
                etc = en && (mpre[i] == divv[i] - 1) &&
                      (up ? (mq[i] == modv[i] - 1) : (mq[i] == 0));
                chk($sformatf("model_q[%0d]", i), qv[i], mq[i]);
                chk($sformatf("model_ovf[%0d]", i), ov[i], movf[i]);
                chk($sformatf("model_tc[%0d]", i), tv[i], etc);
            end
            chk("casc_q0", q_k0, (kn % 100) % 10);
            chk("casc_q1", q_k1, (kn % 100) / 10);
            chk("casc_tc0", tc_k0, (kn % 10) == 9);
            chk("casc_tc1", tc_k1, (kn % 100) == 99);
            chk("casc_ovf0", ovf_k0, kn >= 10);
            chk("casc_ovf1", ovf_k1, kn >= 100);
            if (kn == 99)  chk("casc_99", {q_k1, q_k0}, {4'd9, 4'd9});
            if (kn == 100) chk("casc_00", {q_k1, q_k0}, 8'd0);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst_k = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
        din = 4'd0; sat = 1'b0; ovf_clr = 1'b0;
        repeat (2) edge1();
        chk("reset_q", q_a, 0);
        chk("reset_ovf", ovf_a, 0);

        // Full wrap-mode up count on the 16-state counter
        rst = 1'b1; rst_k = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            edge1();
            chk($sformatf("up_q_%0d", i), q_a, i % 16);
            chk($sformatf("up_tc_%0d", i), tc_a, (i % 16) == 15);
            if (i == 15) chk("up_ovf_before_wrap", ovf_a, 0);
        end
        chk("up_ovf_after_wrap", ovf_a, 1);

        // Down / saturate
        en = 1'b0; ovf_clr = 1'b1; edge1();
        chk("clr_idle_ovf", ovf_a, 0);
        ovf_clr = 1'b0; load = 1'b1; din = 4'd2; en = 1'b1; edge1();
        chk("load2_q", q_a, 2);
        load = 1'b0; up = 1'b0; sat = 1'b1;
        edge1(); chk("dsat_q1", q_a, 1);
        edge1(); chk("dsat_q0", q_a, 0); chk("dsat_ovf_at0", ovf_a, 0);
        edge1(); chk("dsat_hold", q_a, 0); chk("dsat_ovf_set", ovf_a, 1);
        edge1(); chk("dsat_hold2", q_a, 0);
        en = 1'b0; ovf_clr = 1'b1; edge1();
        chk("ovf_clr_pulse", ovf_a, 0);
        en = 1'b1; edge1();
        chk("ovf_set_wins", ovf_a, 1);
        ovf_clr = 1'b0;

        // Decade behaviour
        load = 1'b1; din = 4'd7; edge1();
        chk("dec_load7", q_b, 7);
        load = 1'b0; up = 1'b1; sat = 1'b0;
        edge1(); chk("dec_8", q_b, 8);
        edge1(); chk("dec_9", q_b, 9); chk("dec_tc9", tc_b, 1);
        edge1(); chk("dec_wrap0", q_b, 0);
        load = 1'b1; din = 4'd12; edge1();
        chk("dec_load12_clamp", q_b, 9);
        chk("hex_load12", q_a, 12);
        din = 4'd0; edge1();
        load = 1'b0; up = 1'b0; edge1();
        chk("dec_down_wrap", q_b, 9);
        chk("dec_down_ovf", ovf_b, 1);

        // Prescaled counter
        load = 1'b1; din = 4'd0; edge1();
        load = 1'b0; up = 1'b1; en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            edge1();
            chk($sformatf("div3_q_%0d", k), q_c, k / 3);
        end
        edge1();
        en = 1'b0; edge1(); edge1();
        en = 1'b1; edge1(); chk("div3_gap_hold", q_c, 3);
        edge1(); chk("div3_gap_step", q_c, 4);
        edge1();
        load = 1'b1; din = 4'd5; edge1(); chk("div3_load", q_c, 5);
        load = 1'b0;
        edge1(); edge1(); chk("div3_reload_hold", q_c, 5);
        edge1(); chk("div3_reload_step", q_c, 6);

        // Simultaneous events
        en = 1'b0; ovf_clr = 1'b1; edge1();
        ovf_clr = 1'b0; load = 1'b1; din = 4'd15; edge1();
        en = 1'b1; up = 1'b1; din = 4'd3; edge1();
        chk("load_over_step_q", q_a, 3);
        chk("load_over_step_ovf", ovf_a, 0);
        din = 4'd15; edge1();
        load = 1'b0; sat = 1'b0; edge1();
        chk("wrap_again_ovf", ovf_a, 1);
        rst = 1'b0; load = 1'b1; din = 4'd9; edge1();
        chk("rst_over_load_q", q_a, 0);
        chk("rst_over_load_ovf", ovf_a, 0);
        rst = 1'b1; load = 1'b0; edge1();
        chk("resume_after_rst", q_a, 1);

        // Mixed traffic, checked by the model only
        for (int r = 0; r < 50; r++) begin
            en = 1'($urandom_range(0, 3) != 0);
            up = 1'($urandom);
            sat = 1'($urandom);
            ovf_clr = 1'($urandom_range(0, 7) == 0);
            load = 1'($urandom_range(0, 7) == 0);
            din = 4'($urandom);
            edge1();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit up-counter.
- Adds configurable width and modulus, up/down direction, synchronous parallel load, and wrap/saturate mode.
- Adds a clock-enable prescaler, a terminal-count output for cascading, and a sticky overflow flag.
- Used as the general-purpose counter and timebase in lab designs (decade counters, clock dividers, event counters).

Parameters:
- WIDTH, 4, counter width in bits (≥1)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH
- DIV, 1, prescaler ratio: counter steps once per DIV enabled cycles (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- en  in  1  count enable; gates both prescaler and counter
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load
- din  in  WIDTH  load value
- sat  in  1  boundary mode: 1 = saturate, 0 = wrap
- ovf_clr  in  1  clears sticky overflow flag
- Q  out  WIDTH  current count, registered
- tc  out  1  terminal count, combinational: en & tick & ((up & Q==MAX) | (~up & Q==0))
- ovf  out  1  sticky overflow, registered

Behaviour:
- Reset and constants:
  - Interface: one clock (clk); reset rst is synchronous, active-low.
  - rst==0 at a rising edge sets Q=0, ovf=0, prescaler=0. No other input has effect that cycle.
  - MAX = MODULUS-1.
- Priority per edge: rst > load > step.
- Prescaler:
  - Internal counter pre, 0..DIV-1.
  - tick = (pre==DIV-1). With DIV=1, tick is constant 1.
  - When en=1 and load=0: pre increments, wrapping DIV-1 -> 0.
  - When en=0: pre holds.
  - load=1 clears pre to 0.
- Load:
  - load=1: Q <= min(din, MAX), regardless of en or tick.
  - ovf is unaffected except by ovf_clr.
- Step (load=0, en=1, tick=1):
  - Up and Q<MAX: Q+1.
  - Down and Q>0: Q-1.
  - Up at Q==MAX: wrap mode -> 0; saturate mode -> hold MAX.
  - Down at Q==0: wrap mode -> MAX; saturate mode -> hold 0.
  - Any boundary step (either mode) sets ovf=1 on that edge.
- Hold: en=0 or tick=0 leaves Q unchanged.
- Overflow flag:
  - ovf_clr=1 clears ovf.
  - If ovf_clr and a boundary step occur on the same edge, set wins (ovf=1).
- Dynamic inputs:
  - up and sat may change on any cycle; only the values sampled at the stepping edge matter.
- Cascading: tc of stage N drives en of stage N+1. Only DIV=1 on downstream stages yields a correct multi-digit count.
- Reset mid-operation: Q, ovf and pre all return to 0 on that edge. Counting resumes on the first edge with rst=1.
- Arithmetic: next-value computation at WIDTH+1 bits, compare against MAX before truncation. No X propagation from unused din bits.

Decomposition:
- Package counter_pkg:
  - localparam function clog2 for pre width (max(1, clog2(DIV))).
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Direction constants DIR_DOWN=0, DIR_UP=1.
- Sub-module clk_en_prescaler:
  - Parameter DIV.
  - Ports clk, rst, en, clr, tick.
  - Instantiated once. Reused elsewhere as a standalone clock-enable generator.
- Counter datapath and ovf register stay in the top module.

Test Plan:
- WIDTH=4, MODULUS=16, DIV=1: rst=0 for 2 cycles, then en=1, up=1, sat=0 for 17 cycles -> Q=0,1..15,0. tc=1 only while Q=15. ovf=1 after the wrap edge.
- Down/saturate: load din=2, then up=0, sat=1, en=1 for 4 cycles -> Q=2,1,0,0. ovf=1 from the first hold-at-0 edge. Pulse ovf_clr with en=0 -> ovf=0. Pulse ovf_clr on a boundary step -> ovf stays 1.
- MODULUS=10 (decade): count up from 7 -> 8,9,0. tc=1 at Q=9. Load din=12 -> Q=9. Down-wrap from 0 -> 9.
- DIV=3: en=1, up=1 for 9 cycles -> Q steps 0->1->2->3 on the 3rd, 6th and 9th edges. Drop en for 2 cycles mid-period -> step is delayed by exactly 2 cycles. load mid-period -> pre restarts, next step 3 edges later.
- Simultaneous events: load=1, en=1, up=1 with Q=15 -> Q=din, no ovf set. rst=0 together with load=1 and en=1 -> Q=0, ovf=0.
- Cascade: two instances, WIDTH=4, MODULUS=10, second en=first tc. Run 100 cycles from reset -> digits {Q1,Q0}=00..99, then 00.
